// File: rtl/e_mdu_param_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
// Used by the MDU top, its arithmetic core, and the pipeline controller/stall logic.
package e_mdu_param_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  function automatic logic is_div_op(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_param_core.sv
// Combinational MDU arithmetic: latched operands and op to the next {hi, lo}.
// Optional multiply-accumulate (madd/maddu) is compiled in with MDU_MADD_EN.
module mdu_core
  import e_mdu_param_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mdu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic signed [2*WIDTH-1:0] a_ext, b_ext, prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic [WIDTH-1:0]          a_mag, b_mag, q_mag, r_mag, q_s, r_s;
  logic                      a_neg, b_neg, b_zero;

  assign a_ext  = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext  = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_s = a_ext * b_ext;
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Signed divide via magnitudes; most-negative / -1 naturally yields lo = a, hi = 0.
  assign a_neg  = a[WIDTH-1];
  assign b_neg  = b[WIDTH-1];
  assign b_zero = (b == '0);
  assign a_mag  = a_neg ? (~a + 1'b1) : a;
  assign b_mag  = b_neg ? (~b + 1'b1) : b;
  assign q_mag  = b_zero ? '0 : (a_mag / b_mag);
  assign r_mag  = b_zero ? '0 : (a_mag % b_mag);
  assign q_s    = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
  assign r_s    = a_neg ? (~r_mag + 1'b1) : r_mag;

  always_comb begin
    hi_next = hi_in;
    lo_next = lo_in;
    case (op)
      OP_MULT:  {hi_next, lo_next} = prod_s;
      OP_MULTU: {hi_next, lo_next} = prod_u;
      OP_DIV: begin
        if (b_zero) begin
          hi_next = a;
          lo_next = '1;
        end else begin
          hi_next = r_s;
          lo_next = q_s;
        end
      end
      OP_DIVU: begin
        if (b_zero) begin
          hi_next = a;
          lo_next = '1;
        end else begin
          hi_next = a % b;
          lo_next = a / b;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {hi_next, lo_next} = {hi_in, lo_in} + prod_s;
      OP_MADDU: {hi_next, lo_next} = {hi_in, lo_in} + prod_u;
`endif
      default: begin
        hi_next = hi_in;
        lo_next = lo_in;
      end
    endcase
  end

endmodule

// File: rtl/e_mdu_param.sv
// Multi-cycle multiply/divide unit with HI/LO registers, cancel and mthi/mtlo.
// Define MDU_MADD_EN to enable madd/maddu; otherwise those codes act as none.
module e_mdu_param
  import e_mdu_param_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mduOp,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state, state_next;
  logic [CNT_W-1:0] count, count_next;
  mdu_op_e          op_q, op_next, op_in;
  logic [WIDTH-1:0] a_q, a_next, b_q, b_next;
  logic [WIDTH-1:0] hi_next, lo_next, res_hi, res_lo;
  logic             is_mul;

  assign op_in = mdu_op_e'(mduOp);
  assign busy  = (state != ST_IDLE);

`ifdef MDU_MADD_EN
  assign is_mul = (op_in == OP_MULT) || (op_in == OP_MULTU) ||
                  (op_in == OP_MADD) || (op_in == OP_MADDU);
`else
  assign is_mul = (op_in == OP_MULT) || (op_in == OP_MULTU);
`endif

  mdu_core #(.WIDTH(WIDTH)) u_core (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .hi_in   (hi),
    .lo_in   (lo),
    .hi_next (res_hi),
    .lo_next (res_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      op_q  <= OP_NONE;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      op_q  <= op_next;
      a_q   <= a_next;
      b_q   <= b_next;
      hi    <= hi_next;
      lo    <= lo_next;
    end
  end

  // Cancel beats everything: no launch, no mthi/mtlo, no result write.
  always_comb begin
    state_next = state;
    count_next = count;
    op_next    = op_q;
    a_next     = a_q;
    b_next     = b_q;
    hi_next    = hi;
    lo_next    = lo;
    case (state)
      ST_IDLE: begin
        if (!cancel) begin
          if (start && is_mul) begin
            state_next = ST_MUL;
            count_next = CNT_W'(MUL_CYCLES);
            op_next    = op_in;
            a_next     = d1;
            b_next     = d2;
          end else if (start && is_div_op(op_in)) begin
            state_next = ST_DIV;
            count_next = CNT_W'(DIV_CYCLES);
            op_next    = op_in;
            a_next     = d1;
            b_next     = d2;
          end else if (op_in == OP_MTHI) begin
            hi_next = d1;
          end else if (op_in == OP_MTLO) begin
            lo_next = d1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (cancel) begin
          state_next = ST_IDLE;
          count_next = '0;
        end else if (count == CNT_W'(1)) begin
          state_next = ST_IDLE;
          count_next = '0;
          hi_next    = res_hi;
          lo_next    = res_lo;
        end else begin
          count_next = count - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_e_mdu_param.sv
// Directed self-checking bench for e_mdu_param (WIDTH=32, 5/10 cycle latencies).
// Expectations for the madd sequence follow whether MDU_MADD_EN is defined.
module tb_e_mdu_param;
  import e_mdu_param_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mduOp;
  logic [31:0] d1;
  logic [31:0] d2;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  int n;

  e_mdu_param #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mduOp  (mduOp),
    .d1     (d1),
    .d2     (d2),
    .cancel (cancel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then return the bus to idle with scrambled operands.
  task automatic apply_stimulus(input logic s, input mdu_op_e op, input logic [31:0] a,
                                input logic [31:0] b, input logic c);
    start  = s;
    mduOp  = op;
    d1     = a;
    d2     = b;
    cancel = c;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mduOp  = OP_NONE;
    d1     = $urandom;
    d2     = $urandom;
    cancel = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 64) begin
      cycles++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    mduOp  = OP_NONE;
    d1     = '0;
    d2     = '0;
    cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_hi", hi, 32'd0);
    check_output("reset_lo", lo, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    apply_stimulus(1'b1, OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_idle(n);
    check_output("mult_busy_cycles", n, 32'd5);
    check_output("mult_hi", hi, 32'hFFFFFFFF);
    check_output("mult_lo", lo, 32'hFFFFFFFA);

    apply_stimulus(1'b1, OP_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_idle(n);
    check_output("multu_busy_cycles", n, 32'd5);
    check_output("multu_hi", hi, 32'h00000002);
    check_output("multu_lo", lo, 32'hFFFFFFFA);

    apply_stimulus(1'b1, OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle(n);
    check_output("div_busy_cycles", n, 32'd10);
    check_output("div_lo", lo, 32'hFFFFFFFD);
    check_output("div_hi", hi, 32'hFFFFFFFF);

    apply_stimulus(1'b1, OP_DIVU, 32'd7, 32'd0, 1'b0);
    wait_idle(n);
    check_output("divu0_lo", lo, 32'hFFFFFFFF);
    check_output("divu0_hi", hi, 32'd7);

    apply_stimulus(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
    wait_idle(n);
    check_output("divu_lo", lo, 32'd14);
    check_output("divu_hi", hi, 32'd2);

    apply_stimulus(1'b1, OP_DIV, 32'hFFFFFFF9, 32'd0, 1'b0);
    wait_idle(n);
    check_output("div0_lo", lo, 32'hFFFFFFFF);
    check_output("div0_hi", hi, 32'hFFFFFFF9);

    apply_stimulus(1'b1, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle(n);
    check_output("divovf_lo", lo, 32'h80000000);
    check_output("divovf_hi", hi, 32'd0);

    apply_stimulus(1'b1, OP_DIV, 32'd7, 32'hFFFFFFFE, 1'b0);
    wait_idle(n);
    check_output("div_negdiv_lo", lo, 32'hFFFFFFFD);
    check_output("div_negdiv_hi", hi, 32'd1);

    apply_stimulus(1'b0, OP_MTHI, 32'h11, 32'd0, 1'b0);
    check_output("mthi_busy", {31'd0, busy}, 32'd0);
    check_output("mthi_hi", hi, 32'h11);
    apply_stimulus(1'b0, OP_MTLO, 32'h22, 32'd0, 1'b0);
    check_output("mtlo_lo", lo, 32'h22);

    // mult 4*5 cancelled in its third busy cycle
    apply_stimulus(1'b1, OP_MULT, 32'd4, 32'd5, 1'b0);
    check_output("cancel_busy_c1", {31'd0, busy}, 32'd1);
    apply_stimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    apply_stimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b1);
    check_output("cancel_busy_after", {31'd0, busy}, 32'd0);
    repeat (6) apply_stimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    check_output("cancel_busy_later", {31'd0, busy}, 32'd0);
    check_output("cancel_hi", hi, 32'h11);
    check_output("cancel_lo", lo, 32'h22);

    // start div and mthi while a multu is busy: both ignored
    apply_stimulus(1'b1, OP_MULTU, 32'd2, 32'd3, 1'b0);
    apply_stimulus(1'b0, OP_MTHI, 32'hDEAD, 32'd0, 1'b0);
    apply_stimulus(1'b1, OP_DIV, 32'd100, 32'd3, 1'b0);
    wait_idle(n);
    check_output("busy_window_cycles", n + 2, 32'd5);
    check_output("busy_window_hi", hi, 32'd0);
    check_output("busy_window_lo", lo, 32'd6);
    repeat (3) apply_stimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    check_output("busy_window_no_div", {31'd0, busy}, 32'd0);

    // cancel in IDLE beats start and mthi; none with start is a no-op
    apply_stimulus(1'b1, OP_MULT, 32'd9, 32'd9, 1'b1);
    check_output("idle_cancel_start", {31'd0, busy}, 32'd0);
    apply_stimulus(1'b0, OP_MTHI, 32'h55, 32'd0, 1'b1);
    check_output("idle_cancel_mthi", hi, 32'd0);
    apply_stimulus(1'b1, OP_NONE, 32'd9, 32'd9, 1'b0);
    check_output("none_start_busy", {31'd0, busy}, 32'd0);
    check_output("none_start_lo", lo, 32'd6);

    // reset in the fourth DIV cycle
    apply_stimulus(1'b1, OP_DIV, 32'd100, 32'd3, 1'b0);
    repeat (3) apply_stimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    check_output("div4_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_output("midreset_busy", {31'd0, busy}, 32'd0);
    check_output("midreset_hi", hi, 32'd0);
    check_output("midreset_lo", lo, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (15) apply_stimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    check_output("postreset_busy", {31'd0, busy}, 32'd0);
    check_output("postreset_hi", hi, 32'd0);
    check_output("postreset_lo", lo, 32'd0);

    // madd sequence: mtlo 1, mthi 0, madd 2*3
    apply_stimulus(1'b0, OP_MTLO, 32'd1, 32'd0, 1'b0);
    apply_stimulus(1'b0, OP_MTHI, 32'd0, 32'd0, 1'b0);
    apply_stimulus(1'b1, OP_MADD, 32'd2, 32'd3, 1'b0);
    wait_idle(n);
`ifdef MDU_MADD_EN
    check_output("madd_busy_cycles", n, 32'd5);
    check_output("madd_lo", lo, 32'd7);
`else
    check_output("madd_busy_cycles", n, 32'd0);
    check_output("madd_lo", lo, 32'd1);
`endif
    check_output("madd_hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
